nms_controller: RTL and testbench

//  Consumer of the gradient stage's row output. On each completed gradient row, shifts the
//  row's magnitude/angle into a 3-row window. Then performs non-maximum suppression (NMS)
//  on the centre row, one pixel per cycle, producing 12 thinned edge magnitudes for the

---
 rtl/nms_controller.sv | 173 +++++++++++++++++
 tb/tb_nms_controller.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/nms_controller.sv
// Three-row gradient window with per-pixel non-maximum suppression over the centre row.
// Optional suppression floor enabled by defining NMS_THRESH_EN.
module nms_controller #(
  parameter int IN_PIX    = 14,
  parameter int OUT_PIX   = 12,
  parameter int PRECISION = 8
) (
  input  logic                               clk,
  input  logic                               n_rst,
  input  logic [31:0]                        anchor_x,
  input  logic                               gradient_final,
  input  logic [IN_PIX-1:0][PRECISION-1:0]   gradient_mag,
  input  logic [IN_PIX-1:0][1:0]             gradient_angle,
  output logic [OUT_PIX-1:0][PRECISION-1:0]  nms_out,
  output logic                               nms_final
);
  // state | meaning
  // IDLE  | waiting for a gradient row event
  // PROC  | suppressing centre columns 1..OUT_PIX, one per cycle
  // LOAD  | shifting the staged row into the window
  typedef enum logic [1:0] {IDLE, PROC, LOAD} state_t;
  typedef logic [IN_PIX-1:0][PRECISION-1:0] mag_row_t;
  typedef logic [IN_PIX-1:0][1:0]           ang_row_t;

  localparam int IW = $clog2(OUT_PIX);
  localparam int KW = $clog2(IN_PIX);
`ifdef NMS_THRESH_EN
  localparam logic [PRECISION-1:0] LOW_THRESH = PRECISION'(20);
`endif

  state_t                              state_q, state_d;
  logic [IW-1:0]                       index_q, index_d;
  logic                                final_q, final_d;
  logic                                pending_q, pending_d;
  logic                                stg_anchor_q, stg_anchor_d;
  mag_row_t                            stg_mag_q, stg_mag_d;
  ang_row_t                            stg_ang_q, stg_ang_d;
  mag_row_t                            mag0_q, mag0_d, mag1_q, mag1_d, mag2_q, mag2_d;
  ang_row_t                            ang0_q, ang0_d, ang1_q, ang1_d;
  logic [OUT_PIX-1:0][PRECISION-1:0]   nms_out_q, nms_out_d;

  logic                 row_event;
  logic                 shift_en, shift_rep;
  mag_row_t             shift_mag;
  ang_row_t             shift_ang;
  logic [KW-1:0]        k, km1, kp1;
  logic [PRECISION-1:0] centre, nb_a, nb_b, nms_res;

  assign row_event = gradient_final & ~final_q;

  // Neighbour selection along the gradient direction for centre column k.
  always_comb begin
    k      = KW'(index_q) + KW'(1);
    km1    = k - KW'(1);
    kp1    = k + KW'(1);
    centre = mag1_q[k];
    nb_a   = '0;
    nb_b   = '0;
    case (ang1_q[k])
      2'd0: begin nb_a = mag1_q[km1]; nb_b = mag1_q[kp1]; end
      2'd1: begin nb_a = mag0_q[kp1]; nb_b = mag2_q[km1]; end
      2'd2: begin nb_a = mag0_q[k];   nb_b = mag2_q[k];   end
      default: begin nb_a = mag0_q[km1]; nb_b = mag2_q[kp1]; end
    endcase
    nms_res = (centre >= nb_a && centre >= nb_b) ? centre : '0;
`ifdef NMS_THRESH_EN
    if (centre < LOW_THRESH) nms_res = '0;
`endif
  end

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    final_d      = gradient_final;
    pending_d    = pending_q;
    stg_anchor_d = stg_anchor_q;
    stg_mag_d    = stg_mag_q;
    stg_ang_d    = stg_ang_q;
    mag0_d       = mag0_q;
    mag1_d       = mag1_q;
    mag2_d       = mag2_q;
    ang0_d       = ang0_q;
    ang1_d       = ang1_q;
    nms_out_d    = nms_out_q;
    shift_en     = 1'b0;
    shift_rep    = 1'b0;
    shift_mag    = gradient_mag;
    shift_ang    = gradient_angle;

    case (state_q)
      IDLE: begin
        if (row_event) begin
          shift_en  = 1'b1;
          shift_rep = (anchor_x == 32'd1);
          index_d   = '0;
          state_d   = PROC;
        end
      end
      PROC: begin
        nms_out_d[index_q] = nms_res;
        if (index_q == IW'(OUT_PIX - 1)) begin
          index_d = '0;
          state_d = (pending_q || row_event) ? LOAD : IDLE;
        end else begin
          index_d = index_q + IW'(1);
        end
      end
      LOAD: begin
        shift_en  = 1'b1;
        shift_rep = stg_anchor_q;
        shift_mag = stg_mag_q;
        shift_ang = stg_ang_q;
        pending_d = 1'b0;
        index_d   = '0;
        state_d   = PROC;
      end
      default: state_d = IDLE;
    endcase

    // A row arriving while busy is staged; a later one before LOAD overwrites it.
    if (row_event && state_q != IDLE) begin
      stg_mag_d    = gradient_mag;
      stg_ang_d    = gradient_angle;
      stg_anchor_d = (anchor_x == 32'd1);
      pending_d    = 1'b1;
    end

    if (shift_en) begin
      if (shift_rep) begin
        mag0_d = shift_mag; mag1_d = shift_mag; mag2_d = shift_mag;
        ang0_d = shift_ang; ang1_d = shift_ang;
      end else begin
        mag2_d = mag1_q; mag1_d = mag0_q; mag0_d = shift_mag;
        ang1_d = ang0_q; ang0_d = shift_ang;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      index_q      <= '0;
      final_q      <= 1'b1;
      pending_q    <= 1'b0;
      stg_anchor_q <= 1'b0;
      stg_mag_q    <= '0;
      stg_ang_q    <= '0;
      mag0_q       <= '0;
      mag1_q       <= '0;
      mag2_q       <= '0;
      ang0_q       <= '0;
      ang1_q       <= '0;
      nms_out_q    <= '0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      final_q      <= final_d;
      pending_q    <= pending_d;
      stg_anchor_q <= stg_anchor_d;
      stg_mag_q    <= stg_mag_d;
      stg_ang_q    <= stg_ang_d;
      mag0_q       <= mag0_d;
      mag1_q       <= mag1_d;
      mag2_q       <= mag2_d;
      ang0_q       <= ang0_d;
      ang1_q       <= ang1_d;
      nms_out_q    <= nms_out_d;
    end
  end

  assign nms_out   = nms_out_q;
  assign nms_final = (state_q == IDLE);
endmodule

// File: tb/tb_nms_controller.sv
// Directed bench for nms_controller: latency, suppression patterns, back-to-back rows, reset.
module tb_nms_controller;
  typedef logic [11:0][7:0] out_t;
  typedef logic [13:0][7:0] mag_t;
  typedef logic [13:0][1:0] ang_t;

`ifdef NMS_THRESH_EN
  localparam logic [7:0] RIDGE_BG = 8'd0;
`else
  localparam logic [7:0] RIDGE_BG = 8'd10;
`endif

  logic        clk = 1'b0;
  logic        n_rst;
  logic [31:0] anchor_x;
  logic        gradient_final;
  mag_t        gradient_mag;
  ang_t        gradient_angle;
  out_t        nms_out;
  logic        nms_final;

  int checks = 0;
  int failures = 0;
  int lows;
  out_t exp_out;
  out_t ridge_out;

  nms_controller dut (
    .clk(clk), .n_rst(n_rst), .anchor_x(anchor_x), .gradient_final(gradient_final),
    .gradient_mag(gradient_mag), .gradient_angle(gradient_angle),
    .nms_out(nms_out), .nms_final(nms_final)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic out_t all_out(input logic [7:0] v);
    out_t r;
    for (int i = 0; i < 12; i++) r[i] = v;
    return r;
  endfunction

  task automatic set_row(input logic [7:0] v, input logic [1:0] a);
    for (int i = 0; i < 14; i++) begin
      gradient_mag[i]   = v;
      gradient_angle[i] = a;
    end
  endtask

  // Event is sampled at the edge between the two negedges; returns one negedge after it.
  task automatic pulse(input logic anc);
    @(negedge clk);
    anchor_x       = anc ? 32'd1 : 32'd5;
    gradient_final = 1'b1;
    @(negedge clk);
    gradient_final = 1'b0;
  endtask

  task automatic do_row(input logic anc, input string tag);
    pulse(anc);
    check({tag, "_busy_first"}, 96'(nms_final), 96'(1'b0));
    tick(11);
    check({tag, "_busy_last"}, 96'(nms_final), 96'(1'b0));
    tick(1);
    check({tag, "_done"}, 96'(nms_final), 96'(1'b1));
  endtask

  initial begin
    n_rst          = 1'b0;
    anchor_x       = 32'd0;
    gradient_final = 1'b0;
    gradient_mag   = '0;
    gradient_angle = '0;
    ridge_out      = all_out(RIDGE_BG);
    ridge_out[6]   = 8'd90;
    ridge_out[5]   = 8'd0;
    ridge_out[7]   = 8'd0;
    tick(3);
    check("reset_final", 96'(nms_final), 96'(1'b1));
    check("reset_out", 96'(nms_out), 96'(out_t'(0)));
    n_rst = 1'b1;
    tick(2);

    // Flat column start: ties keep every pixel.
    set_row(8'd50, 2'd0);
    do_row(1'b1, "init");
    check("init_out", 96'(nms_out), 96'(all_out(8'd50)));

    // Horizontal ridge, with a mid-row look at partially rewritten output.
    set_row(8'd10, 2'd0);
    gradient_mag[7] = 8'd90;
    pulse(1'b1);
    check("ridge_busy", 96'(nms_final), 96'(1'b0));
    tick(1);
    check("ridge_col0_new", 96'(nms_out[0]), 96'(RIDGE_BG));
    check("ridge_col1_old", 96'(nms_out[1]), 96'(8'd50));
    tick(10);
    check("ridge_busy_last", 96'(nms_final), 96'(1'b0));
    tick(1);
    check("ridge_done", 96'(nms_final), 96'(1'b1));
    check("ridge_out", 96'(nms_out), 96'(ridge_out));

    // Vertical: centre col 5 = 40 against row0 = 60, then row0 = 30.
    for (int pass = 0; pass < 2; pass++) begin
      set_row(8'd10, 2'd0);
      do_row(1'b1, "vert_a");
      set_row(8'd20, 2'd2);
      gradient_mag[5] = 8'd40;
      do_row(1'b0, "vert_b");
      set_row(8'd15, 2'd0);
      gradient_mag[5] = (pass == 0) ? 8'd60 : 8'd30;
      do_row(1'b0, "vert_c");
      exp_out    = all_out(8'd20);
      exp_out[4] = (pass == 0) ? 8'd0 : 8'd40;
      check((pass == 0) ? "vert_suppress" : "vert_keep", 96'(nms_out), 96'(exp_out));
    end

    // Diagonals: oldest row rises 10/col, newest falls 10/col, centre flat 60 at 45/135.
    for (int j = 0; j < 14; j++) begin
      gradient_mag[j] = 8'(10 * j);
      gradient_angle[j] = 2'd0;
    end
    do_row(1'b1, "diag_a");
    for (int j = 0; j < 14; j++) begin
      gradient_mag[j] = 8'd60;
      gradient_angle[j] = (j % 2 == 0) ? 2'd1 : 2'd3;
    end
    do_row(1'b0, "diag_b");
    for (int j = 0; j < 14; j++) begin
      gradient_mag[j] = 8'(10 * (13 - j));
      gradient_angle[j] = 2'd0;
    end
    do_row(1'b0, "diag_c");
    exp_out    = all_out(8'd0);
    exp_out[5] = 8'd60;
    check("diag_out", 96'(nms_out), 96'(exp_out));

    // Back-to-back: second row arrives at PROC cycle 5, staged then loaded.
    set_row(8'd50, 2'd0);
    pulse(1'b1);
    tick(4);
    set_row(8'd10, 2'd0);
    gradient_mag[7] = 8'd90;
    anchor_x        = 32'd1;
    gradient_final  = 1'b1;
    tick(1);
    gradient_final  = 1'b0;
    set_row(8'd0, 2'd0);
    tick(7);
    check("b2b_load_busy", 96'(nms_final), 96'(1'b0));
    check("b2b_first_out", 96'(nms_out), 96'(all_out(8'd50)));
    tick(12);
    check("b2b_busy_last", 96'(nms_final), 96'(1'b0));
    tick(1);
    check("b2b_done", 96'(nms_final), 96'(1'b1));
    check("b2b_second_out", 96'(nms_out), 96'(ridge_out));

    // Level held high for 40 cycles must yield exactly one row.
    set_row(8'd77, 2'd0);
    @(negedge clk);
    anchor_x       = 32'd1;
    gradient_final = 1'b1;
    lows = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!nms_final) lows++;
    end
    gradient_final = 1'b0;
    tick(2);
    check("edge_busy_cycles", 96'(lows), 96'(12));
    check("edge_final", 96'(nms_final), 96'(1'b1));
    check("edge_out", 96'(nms_out), 96'(all_out(8'd77)));

    // Reset mid-row; a level held through reset release is not a new event.
    set_row(8'd33, 2'd0);
    pulse(1'b1);
    tick(5);
    n_rst          = 1'b0;
    gradient_final = 1'b1;
    tick(1);
    check("rst_mid_out", 96'(nms_out), 96'(out_t'(0)));
    check("rst_mid_final", 96'(nms_final), 96'(1'b1));
    n_rst = 1'b1;
    lows = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!nms_final) lows++;
    end
    gradient_final = 1'b0;
    check("rst_quiet", 96'(lows), 96'(0));
    check("rst_out_held", 96'(nms_out), 96'(out_t'(0)));
    do_row(1'b1, "post_rst");
    check("post_rst_out", 96'(nms_out), 96'(all_out(8'd33)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
